debug_dump_sequencer: RTL and testbench
=======================================

DEBUG_DUMP_SEQUENCER -- requirements
Module: debug_dump_sequencer

Interface
REQ-001 Parameter NB_DATA, default 32: data word width.
REQ-002 Parameter NB_BYTE, default 8: UART byte width.
REQ-003 Parameter NB_ADDR, default 5: register-bank and data-memory word address width.
REQ-004 Parameter N_BR_WORDS, default 32: register-bank words dumped.
REQ-005 Parameter N_DM_WORDS, default 32: data-memory words dumped.
REQ-006 The clock port SHALL be i_clock (input, 1), the single clock.
REQ-007 The reset port SHALL be i_reset (input, 1), synchronous, active-high.
REQ-008 i_start (input, 1): dump request, sampled only in IDLE.
REQ-009 i_sel (input, 2): dump source; 00 = register bank, 01 = data memory, 10 = PC, 11 = reserved.
REQ-010 o_br_addr (output, NB_ADDR): register-bank debug read address.
REQ-011 i_br_data (input, NB_DATA): register-bank read data, valid 1 cycle after address.
REQ-012 o_dm_addr (output, NB_ADDR): data-memory debug read address.
REQ-013 o_dm_re (output, 1): data-memory debug read enable.
REQ-014 i_dm_data (input, NB_DATA): data-memory read data, valid 1 cycle after address with o_dm_re=1.
REQ-015 i_pc (input, NB_DATA): current program counter.
REQ-016 o_tx_data (output, NB_BYTE): byte to UART TX.
REQ-017 o_tx_start (output, 1): one-cycle TX launch pulse.
REQ-018 i_tx_done (input, 1): UART TX byte-complete pulse.
REQ-019 o_busy (output, 1): dump in progress.
REQ-020 o_done (output, 1): one-cycle completion pulse.

Function
REQ-021 FSM states SHALL be IDLE, FETCH, LATCH, SEND, WAIT, NEXT, DONE.
REQ-022 IDLE: on i_start=1 with i_sel in {00,01,10}, go to FETCH with word counter 0 and byte counter 0; with i_sel=11, go to DONE and send no bytes.
REQ-023 FETCH: drive o_br_addr/o_dm_addr = word counter, o_dm_re=1 when i_sel=01; next state LATCH.
REQ-024 LATCH: capture i_br_data, i_dm_data or i_pc (per latched i_sel) into the word shift register; next state SEND.
REQ-025 i_sel SHALL be latched at start; changes during a dump have no effect.
REQ-026 SEND: o_tx_start=1 for exactly one cycle; next state WAIT.
REQ-027 o_tx_data SHALL equal the current byte from the SEND cycle until i_tx_done is seen, and stay stable throughout.
REQ-028 Byte order SHALL be little-endian: bits [7:0] first, [31:24] last.
REQ-029 WAIT: hold until i_tx_done=1, then go to NEXT; i_tx_done in any other state is ignored.
REQ-030 NEXT: if byte counter < 3, shift the word right 8, increment byte counter, go to SEND; else if word counter < N_words-1, increment word counter, clear byte counter, go to FETCH; else go to DONE.
REQ-031 N_words SHALL be N_BR_WORDS for 00, N_DM_WORDS for 01, and 1 for 10.
REQ-032 DONE: o_done=1 for one cycle; next state IDLE.
REQ-033 o_busy SHALL be 1 in every state except IDLE.
REQ-034 Latency: i_start sampled at cycle N gives o_tx_start at cycle N+3.
REQ-035 i_start asserted while o_busy=1 SHALL be ignored and not queued.
REQ-036 Total o_tx_start pulses per dump SHALL be 128 for BR, 128 for DM, 4 for PC, 0 for reserved.
REQ-037 The word counter SHALL be sized to NB_ADDR+1 bits, so reaching 31 with N_words=32 does not wrap before termination.

Reset
REQ-038 On i_reset=1 at a clock edge, from any state, the FSM SHALL go to IDLE.
REQ-039 Reset SHALL clear the word counter, byte counter and shift register, and all outputs SHALL be 0 (o_tx_start, o_done, o_busy, o_dm_re, addresses, o_tx_data).
REQ-040 A reset mid-dump SHALL produce no further o_tx_start or o_done pulses, and no partial dump SHALL resume.

Structure
REQ-041 State encodings, i_sel codes and byte-order constant SHALL reside in the shared debug definitions header, also used by the debug unit.
REQ-042 The byte serializer (shift register, byte counter, SEND/WAIT handshake) SHALL be one sub-module, word_to_byte_tx; the sequencer owns source select, address generation and word counting.

Verification
REQ-043 PC dump: i_pc=32'h0000_0010, i_sel=10, i_start pulse, i_tx_done returned 5 cycles after each start -> bytes 10,00,00,00, then one o_done pulse.
REQ-044 BR dump: register k holds k*4, i_sel=00 -> 128 bytes; word 31 bytes 7C,00,00,00; o_br_addr sweeps 0..31; o_done once.
REQ-045 DM dump with i_tx_done delayed 200 cycles per byte: o_tx_data stable and exactly one o_tx_start per byte; o_dm_re high only in FETCH.
REQ-046 i_start re-asserted with i_sel=01 mid BR dump, plus a spurious i_tx_done in SEND -> neither affects the dump; still 128 bytes of BR data.
REQ-047 i_reset during byte 2 of word 5 of a BR dump -> outputs 0 next cycle, no o_done; a new PC dump then works normally.
REQ-048 i_sel=11 start -> o_done at N+1, zero o_tx_start pulses, o_busy high for one cycle.

Source files
------------

// File: rtl/debug_dump_sequencer_pkg.sv
// Shared debug definitions: FSM state encodings, dump-source select codes and
// the byte-order constant used by the sequencer and by the debug unit.
package debug_dump_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LATCH = 3'd2,
        ST_SEND  = 3'd3,
        ST_WAIT  = 3'd4,
        ST_NEXT  = 3'd5,
        ST_DONE  = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        SEL_BR   = 2'b00,
        SEL_DM   = 2'b01,
        SEL_PC   = 2'b10,
        SEL_RSVD = 2'b11
    } sel_e;

    // Words leave the UART least-significant byte first.
    localparam bit BYTE_ORDER_LSB_FIRST = 1'b1;

    function automatic logic sel_is_dump(input logic [1:0] sel);
        return sel != SEL_RSVD;
    endfunction

endpackage

// File: rtl/debug_dump_sequencer_if.sv
// Debug read buses (register bank, data memory, PC) and the UART TX handshake
// between the dump sequencer (master) and its surroundings (slave).
interface debug_dump_sequencer_if #(
    parameter int NB_DATA = 32,
    parameter int NB_BYTE = 8,
    parameter int NB_ADDR = 5
);
    logic [NB_ADDR-1:0] o_br_addr;
    logic [NB_DATA-1:0] i_br_data;
    logic [NB_ADDR-1:0] o_dm_addr;
    logic               o_dm_re;
    logic [NB_DATA-1:0] i_dm_data;
    logic [NB_DATA-1:0] i_pc;
    logic [NB_BYTE-1:0] o_tx_data;
    logic               o_tx_start;
    logic               i_tx_done;

    modport master (
        output o_br_addr, o_dm_addr, o_dm_re, o_tx_data, o_tx_start,
        input  i_br_data, i_dm_data, i_pc, i_tx_done
    );

    modport slave (
        input  o_br_addr, o_dm_addr, o_dm_re, o_tx_data, o_tx_start,
        output i_br_data, i_dm_data, i_pc, i_tx_done
    );
endinterface

// File: rtl/debug_dump_sequencer_word_to_byte_tx.sv
// Byte serializer: holds the latched word, walks it byte by byte and drives
// the UART launch/complete handshake under control of the dump sequencer.
module word_to_byte_tx
    import debug_dump_sequencer_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int NB_BYTE = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic [NB_DATA-1:0] word_i,
    input  logic               send_i,
    input  logic               wait_i,
    input  logic               shift_i,
    input  logic               tx_done_i,
    output logic [NB_BYTE-1:0] tx_data_o,
    output logic               tx_start_o,
    output logic               byte_done_o,
    output logic               last_byte_o
);
    localparam int N_BYTES = NB_DATA / NB_BYTE;
    localparam int NB_BCNT = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

    logic [NB_DATA-1:0] word_q, word_d;
    logic [NB_BCNT-1:0] bcnt_q, bcnt_d;

    always_comb begin
        word_d = word_q;
        bcnt_d = bcnt_q;
        if (load_i) begin
            word_d = word_i;
            bcnt_d = '0;
        end else if (shift_i) begin
            word_d = BYTE_ORDER_LSB_FIRST ? (word_q >> NB_BYTE) : (word_q << NB_BYTE);
            bcnt_d = bcnt_q + NB_BCNT'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            word_q <= '0;
            bcnt_q <= '0;
        end else begin
            word_q <= word_d;
            bcnt_q <= bcnt_d;
        end
    end

    // The shift register only moves in NEXT, so the byte on the UART stays
    // put for the whole SEND..WAIT window.
    assign tx_data_o   = BYTE_ORDER_LSB_FIRST ? word_q[NB_BYTE-1:0]
                                              : word_q[NB_DATA-1 -: NB_BYTE];
    assign tx_start_o  = send_i;
    assign byte_done_o = wait_i & tx_done_i;
    assign last_byte_o = (bcnt_q == NB_BCNT'(N_BYTES - 1));

endmodule

// File: rtl/debug_dump_sequencer.sv
// Debug dump sequencer: on request, streams the register bank, data memory or
// PC out over the UART; owns source select, address generation, word counting.
module debug_dump_sequencer
    import debug_dump_sequencer_pkg::*;
#(
    parameter int NB_DATA    = 32,
    parameter int NB_BYTE    = 8,
    parameter int NB_ADDR    = 5,
    parameter int N_BR_WORDS = 32,
    parameter int N_DM_WORDS = 32
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_start,
    input  logic [1:0]             i_sel,
    output logic                   o_busy,
    output logic                   o_done,
    debug_dump_sequencer_if.master bus
);
    // One extra bit so the counter can represent N_words without wrapping.
    localparam int                 NB_WCNT = NB_ADDR + 1;
    localparam logic [NB_WCNT-1:0] BR_LAST = NB_WCNT'(N_BR_WORDS - 1);
    localparam logic [NB_WCNT-1:0] DM_LAST = NB_WCNT'(N_DM_WORDS - 1);

    state_e             state_q, state_d;
    sel_e               sel_q, sel_d;
    logic [NB_WCNT-1:0] wcnt_q, wcnt_d;
    logic [NB_WCNT-1:0] last_word;
    logic [NB_DATA-1:0] src_word;
    logic               load, shift, byte_done, last_byte;

    always_comb begin
        last_word = '0;
        src_word  = bus.i_pc;
        case (sel_q)
            SEL_BR: begin
                last_word = BR_LAST;
                src_word  = bus.i_br_data;
            end
            SEL_DM: begin
                last_word = DM_LAST;
                src_word  = bus.i_dm_data;
            end
            default: begin
                last_word = '0;
                src_word  = bus.i_pc;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            sel_q   <= SEL_BR;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            wcnt_q  <= wcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        wcnt_d  = wcnt_q;
        load    = 1'b0;
        shift   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    sel_d   = sel_e'(i_sel);
                    wcnt_d  = '0;
                    state_d = sel_is_dump(i_sel) ? ST_FETCH : ST_DONE;
                end
            end
            ST_FETCH: state_d = ST_LATCH;
            ST_LATCH: begin
                load    = 1'b1;
                state_d = ST_SEND;
            end
            ST_SEND: state_d = ST_WAIT;
            ST_WAIT: begin
                if (byte_done) state_d = ST_NEXT;
            end
            ST_NEXT: begin
                if (!last_byte) begin
                    shift   = 1'b1;
                    state_d = ST_SEND;
                end else if (wcnt_q < last_word) begin
                    wcnt_d  = wcnt_q + NB_WCNT'(1);
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Addresses are only presented during FETCH and read as zero otherwise.
    assign bus.o_br_addr = (state_q == ST_FETCH) ? wcnt_q[NB_ADDR-1:0] : '0;
    assign bus.o_dm_addr = (state_q == ST_FETCH) ? wcnt_q[NB_ADDR-1:0] : '0;
    assign bus.o_dm_re   = (state_q == ST_FETCH) && (sel_q == SEL_DM);
    assign o_busy        = (state_q != ST_IDLE);
    assign o_done        = (state_q == ST_DONE);

    word_to_byte_tx #(
        .NB_DATA (NB_DATA),
        .NB_BYTE (NB_BYTE)
    ) u_ser (
        .clk_i       (i_clock),
        .rst_i       (i_reset),
        .load_i      (load),
        .word_i      (src_word),
        .send_i      (state_q == ST_SEND),
        .wait_i      (state_q == ST_WAIT),
        .shift_i     (shift),
        .tx_done_i   (bus.i_tx_done),
        .tx_data_o   (bus.o_tx_data),
        .tx_start_o  (bus.o_tx_start),
        .byte_done_o (byte_done),
        .last_byte_o (last_byte)
    );

endmodule

// File: tb/tb_debug_dump_sequencer.sv
// Self-checking bench for debug_dump_sequencer: memory and UART models plus a
// byte-stream reference built directly from the memory contents.
module tb_debug_dump_sequencer;
    localparam int NB_DATA = 32;
    localparam int NB_BYTE = 8;
    localparam int NB_ADDR = 5;
    localparam int N_BR    = 32;
    localparam int N_DM    = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] sel = 2'b00;
    logic       busy, done;
    logic       resp_done = 1'b0;
    logic       spur_done = 1'b0;
    int         tx_delay = 5;

    logic [31:0] br_mem [N_BR];
    logic [31:0] dm_mem [N_DM];
    logic [31:0] pc = 32'h0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    debug_dump_sequencer_if #(.NB_DATA(NB_DATA), .NB_BYTE(NB_BYTE), .NB_ADDR(NB_ADDR)) bus ();

    debug_dump_sequencer #(
        .NB_DATA(NB_DATA), .NB_BYTE(NB_BYTE), .NB_ADDR(NB_ADDR),
        .N_BR_WORDS(N_BR), .N_DM_WORDS(N_DM)
    ) dut (
        .i_clock (clk),
        .i_reset (rst),
        .i_start (start),
        .i_sel   (sel),
        .o_busy  (busy),
        .o_done  (done),
        .bus     (bus)
    );

    assign bus.i_tx_done = resp_done | spur_done;
    assign bus.i_pc      = pc;

    // Synchronous-read memories: data one cycle after the address.
    always @(posedge clk) begin
        bus.i_br_data <= br_mem[bus.o_br_addr];
        if (bus.o_dm_re) bus.i_dm_data <= dm_mem[bus.o_dm_addr];
    end

    // UART model: completes each byte tx_delay cycles after its launch.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.o_tx_start) begin
                repeat (tx_delay) @(posedge clk);
                #1 resp_done = 1'b1;
                @(posedge clk);
                #1 resp_done = 1'b0;
            end
        end
    end

    logic [7:0]         captured [$];
    logic [7:0]         exp_q [$];
    logic [NB_ADDR-1:0] br_addr_q [$];
    logic [NB_ADDR-1:0] dm_addr_q [$];
    int   done_cnt, dm_re_cnt, dm_re_hit, unstable, dbl_start;
    logic pending, prev_start;
    logic [7:0] hold;
    logic [NB_ADDR-1:0] br_d1, br_d2, dm_d1, dm_d2;
    logic re_d1, re_d2;

    initial begin
        done_cnt = 0; dm_re_cnt = 0; dm_re_hit = 0; unstable = 0; dbl_start = 0;
        pending = 1'b0; prev_start = 1'b0; hold = '0;
        br_d1 = '0; br_d2 = '0; dm_d1 = '0; dm_d2 = '0; re_d1 = 1'b0; re_d2 = 1'b0;
    end

    always @(negedge clk) begin
        if (bus.o_tx_start) begin
            if (prev_start) dbl_start++;
            if (captured.size() % 4 == 0) begin
                br_addr_q.push_back(br_d2);
                dm_addr_q.push_back(dm_d2);
                if (re_d2) dm_re_hit++;
            end
            captured.push_back(bus.o_tx_data);
            hold    = bus.o_tx_data;
            pending = 1'b1;
        end else if (pending) begin
            if (bus.o_tx_data !== hold) unstable++;
            if (bus.i_tx_done) pending = 1'b0;
        end
        prev_start = bus.o_tx_start;
        if (done) done_cnt++;
        if (bus.o_dm_re) dm_re_cnt++;
        br_d2 = br_d1; br_d1 = bus.o_br_addr;
        dm_d2 = dm_d1; dm_d1 = bus.o_dm_addr;
        re_d2 = re_d1; re_d1 = bus.o_dm_re;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_mon();
        captured.delete(); br_addr_q.delete(); dm_addr_q.delete();
        done_cnt = 0; dm_re_cnt = 0; dm_re_hit = 0; unstable = 0; dbl_start = 0;
        pending = 1'b0;
    endtask

    // Reference byte stream: each source word, least-significant byte first.
    task automatic build_expected(input logic [1:0] s);
        int nw;
        logic [31:0] w;
        exp_q.delete();
        nw = (s == 2'b00) ? N_BR : (s == 2'b01) ? N_DM : (s == 2'b10) ? 1 : 0;
        for (int i = 0; i < nw; i++) begin
            w = (s == 2'b00) ? br_mem[i] : (s == 2'b01) ? dm_mem[i] : pc;
            for (int b = 0; b < 4; b++) exp_q.push_back(8'((w >> (8 * b)) & 32'hFF));
        end
    endtask

    function automatic int first_diff();
        int n;
        n = (captured.size() < exp_q.size()) ? captured.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (captured[i] !== exp_q[i]) return i;
        if (captured.size() != exp_q.size()) return n;
        return -1;
    endfunction

    task automatic wait_done(input int limit, output bit ok);
        int k;
        k = 0;
        while (done_cnt == 0 && k < limit) begin
            @(negedge clk);
            k++;
        end
        ok = (done_cnt != 0);
    endtask

    task automatic launch(input logic [1:0] s);
        @(negedge clk);
        sel   = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] outs;
        rst = 1'b1; start = 1'b0;
        repeat (3) @(negedge clk);
        outs = {8'(busy), 8'(done), 8'(bus.o_tx_start), 8'(bus.o_dm_re)};
        checks++;
        if (outs !== 32'h0 || bus.o_br_addr !== '0 || bus.o_dm_addr !== '0 || bus.o_tx_data !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy/done/start/re=%h br=%h dm=%h tx=%h required all 0",
                     outs, bus.o_br_addr, bus.o_dm_addr, bus.o_tx_data);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_busy: got %b required 0", busy);
        end
    endtask

    task automatic test_pc_dump();
        int lat, d;
        bit ok;
        pc = 32'h0000_0010; tx_delay = 5;
        clear_mon();
        @(negedge clk);
        sel = 2'b10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!bus.o_tx_start && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != 3) begin
            errors++;
            $display("FAIL pc_latency: got %0d cycles required 3", lat);
        end
        wait_done(200, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL pc_timeout: no o_done got 0 required 1");
        end
        build_expected(2'b10);
        d = first_diff();
        checks++;
        if (captured.size() != 4 || d != -1) begin
            errors++;
            $display("FAIL pc_bytes: got %0d bytes (diff at %0d) required 10 00 00 00", captured.size(), d);
        end
        @(negedge clk);
        checks++;
        if (done_cnt != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL pc_done: done pulses %0d busy %b required 1 and 0", done_cnt, busy);
        end
    endtask

    task automatic test_br_dump();
        int d;
        bit ok, sweep_ok;
        for (int k = 0; k < N_BR; k++) br_mem[k] = 32'(k * 4);
        tx_delay = 5;
        clear_mon();
        launch(2'b00);
        wait_done(5000, ok);
        build_expected(2'b00);
        d = first_diff();
        checks++;
        if (!ok || captured.size() != 128 || d != -1) begin
            errors++;
            $display("FAIL br_bytes: got %0d bytes done=%b diff at %0d required 128", captured.size(), ok, d);
        end
        checks++;
        if (captured.size() != 128 || captured[124] !== 8'h7C || captured[125] !== 8'h00 ||
            captured[126] !== 8'h00 || captured[127] !== 8'h00) begin
            errors++;
            $display("FAIL br_word31: got %0d bytes required 7C 00 00 00 at the end", captured.size());
        end
        sweep_ok = (br_addr_q.size() == N_BR);
        for (int k = 0; k < br_addr_q.size(); k++) if (br_addr_q[k] !== NB_ADDR'(k)) sweep_ok = 1'b0;
        checks++;
        if (!sweep_ok) begin
            errors++;
            $display("FAIL br_addr_sweep: %0d fetch addresses, not 0..31 in order", br_addr_q.size());
        end
        @(negedge clk);
        checks++;
        if (done_cnt != 1 || dm_re_cnt != 0) begin
            errors++;
            $display("FAIL br_done: done pulses %0d dm_re cycles %0d required 1 and 0", done_cnt, dm_re_cnt);
        end
    endtask

    task automatic test_dm_slow();
        int d;
        bit ok, sweep_ok;
        for (int k = 0; k < N_DM; k++) dm_mem[k] = $urandom;
        tx_delay = 200;
        clear_mon();
        launch(2'b01);
        wait_done(40000, ok);
        build_expected(2'b01);
        d = first_diff();
        checks++;
        if (!ok || d != -1) begin
            errors++;
            $display("FAIL dm_bytes: got %0d bytes done=%b diff at %0d required 128", captured.size(), ok, d);
        end
        checks++;
        if (unstable != 0 || dbl_start != 0 || captured.size() != 128) begin
            errors++;
            $display("FAIL dm_handshake: unstable %0d double starts %0d starts %0d required 0 0 128",
                     unstable, dbl_start, captured.size());
        end
        checks++;
        if (dm_re_cnt != N_DM || dm_re_hit != N_DM) begin
            errors++;
            $display("FAIL dm_re: re cycles %0d in-fetch %0d required 32 and 32", dm_re_cnt, dm_re_hit);
        end
        sweep_ok = (dm_addr_q.size() == N_DM);
        for (int k = 0; k < dm_addr_q.size(); k++) if (dm_addr_q[k] !== NB_ADDR'(k)) sweep_ok = 1'b0;
        checks++;
        if (!sweep_ok || done_cnt != 1) begin
            errors++;
            $display("FAIL dm_addr_done: sweep ok %b done pulses %0d required 1 and 1", sweep_ok, done_cnt);
        end
    endtask

    task automatic test_ignore_start_and_spurious_done();
        int d, k;
        bit ok;
        for (int i = 0; i < N_BR; i++) br_mem[i] = $urandom;
        tx_delay = $urandom_range(2, 4);
        clear_mon();
        launch(2'b00);
        k = 0;
        while (captured.size() < 40 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        sel = 2'b01; start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!bus.o_tx_start && k < 100) begin
            @(negedge clk);
            k++;
        end
        spur_done = 1'b1;
        @(posedge clk);
        #1 spur_done = 1'b0;
        wait_done(5000, ok);
        build_expected(2'b00);
        d = first_diff();
        checks++;
        if (!ok || d != -1) begin
            errors++;
            $display("FAIL ignore_bytes: got %0d bytes done=%b diff at %0d required 128 BR bytes",
                     captured.size(), ok, d);
        end
        @(negedge clk);
        checks++;
        if (done_cnt != 1 || dm_re_cnt != 0) begin
            errors++;
            $display("FAIL ignore_done: done pulses %0d dm_re cycles %0d required 1 and 0", done_cnt, dm_re_cnt);
        end
        sel = 2'b00;
    endtask

    task automatic test_reset_mid_dump();
        int d, k;
        bit ok;
        for (int i = 0; i < N_BR; i++) br_mem[i] = 32'(i * 4);
        tx_delay = 5;
        clear_mon();
        launch(2'b00);
        k = 0;
        while (captured.size() < 23 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || bus.o_tx_start !== 1'b0 || bus.o_dm_re !== 1'b0 ||
            bus.o_br_addr !== '0 || bus.o_dm_addr !== '0 || bus.o_tx_data !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: busy %b done %b start %b tx %h required all 0",
                     busy, done, bus.o_tx_start, bus.o_tx_data);
        end
        rst = 1'b0;
        repeat (30) @(negedge clk);
        checks++;
        if (captured.size() != 23 || done_cnt != 0) begin
            errors++;
            $display("FAIL midreset_quiet: starts %0d done pulses %0d required 23 and 0",
                     captured.size(), done_cnt);
        end
        pc = $urandom;
        clear_mon();
        launch(2'b10);
        wait_done(200, ok);
        build_expected(2'b10);
        d = first_diff();
        checks++;
        if (!ok || d != -1) begin
            errors++;
            $display("FAIL midreset_pc: got %0d bytes done=%b diff at %0d required 4", captured.size(), ok, d);
        end
        @(negedge clk);
    endtask

    task automatic test_reserved();
        clear_mon();
        @(negedge clk);
        sel = 2'b11; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rsvd_n1: done %b busy %b required 1 and 1", done, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rsvd_n2: done %b busy %b required 0 and 0", done, busy);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (captured.size() != 0 || done_cnt != 1) begin
            errors++;
            $display("FAIL rsvd_count: starts %0d done pulses %0d required 0 and 1", captured.size(), done_cnt);
        end
    endtask

    task automatic test_random_dumps();
        logic [1:0] s;
        int d;
        bit ok;
        for (int it = 0; it < 4; it++) begin
            s = 2'($urandom_range(0, 3));
            for (int i = 0; i < N_BR; i++) br_mem[i] = $urandom;
            for (int i = 0; i < N_DM; i++) dm_mem[i] = $urandom;
            pc = $urandom;
            tx_delay = $urandom_range(1, 4);
            clear_mon();
            launch(s);
            sel = 2'($urandom);
            wait_done(5000, ok);
            build_expected(s);
            d = first_diff();
            @(negedge clk);
            checks++;
            if (!ok || d != -1 || done_cnt != 1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL random_dump%0d: sel %b bytes %0d diff at %0d done pulses %0d required %0d bytes, 1 done",
                         it, s, captured.size(), d, done_cnt, exp_q.size());
            end
            repeat (8) @(negedge clk);
        end
    endtask

    initial begin
        for (int i = 0; i < N_BR; i++) br_mem[i] = '0;
        for (int i = 0; i < N_DM; i++) dm_mem[i] = '0;
        test_reset();
        test_pc_dump();
        test_br_dump();
        test_dm_slow();
        test_ignore_start_and_spurious_done();
        test_reset_mid_dump();
        test_reserved();
        test_random_dumps();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
